// File: rtl/mips_encode.sv
// mips_encode: turns instruction descriptors into 32-bit MIPS instruction words.
// It is the inverse of the core decoder. It expands the LI, MOVE and NOP pseudo-ops and
// drops descriptors that the decoder would flag as reserved-instruction.
// There is a single output register. A second LI word waits in a side register.
module mips_encode (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_fmt,
    input  logic [5:0]  req_op,
    input  logic [5:0]  req_funct,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_shamt,
    input  logic [31:0] req_imm,
    input  logic [25:0] req_target,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_word,
    output logic        ins_last,
    output logic        err_pulse,
    output logic [15:0] enc_count
);

    localparam logic [2:0] FmtR      = 3'd0;
    localparam logic [2:0] FmtI      = 3'd1;
    localparam logic [2:0] FmtRegimm = 3'd2;
    localparam logic [2:0] FmtJ      = 3'd3;
    localparam logic [2:0] FmtLi     = 3'd4;
    localparam logic [2:0] FmtNop    = 3'd5;
    localparam logic [2:0] FmtMove   = 3'd6;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StEmit   = 2'd1;
    localparam logic [1:0] StEmitHi = 2'd2;

    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpRegimm  = 6'h01;
    localparam logic [5:0] OpOri     = 6'h0D;
    localparam logic [5:0] OpLui     = 6'h0F;
    localparam logic [5:0] FnAddu    = 6'h21;

    logic [1:0]  state_q, state_d;
    logic [31:0] word_q, word_d;
    logic        last_q, last_d;
    logic [31:0] pend_q, pend_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;

    logic        accept;
    logic        handoff;
    logic        dec_legal;
    logic [31:0] dec_word0;
    logic        dec_last0;
    logic [31:0] dec_word1;

    // R-type funct values the decoder accepts.
    function automatic logic funct_ok(input logic [5:0] f);
        unique case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C,
            6'h10, 6'h11, 6'h12, 6'h13,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B: funct_ok = 1'b1;
            default:      funct_ok = 1'b0;
        endcase
    endfunction

    // I-type primary opcodes the decoder accepts.
    function automatic logic iop_ok(input logic [5:0] op);
        unique case (op)
            6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: iop_ok = 1'b1;
            default:                                               iop_ok = 1'b0;
        endcase
    endfunction

    // REGIMM branch codes (BLTZ, BGEZ, BLTZAL, BGEZAL).
    function automatic logic regimm_ok(input logic [4:0] rt);
        unique case (rt)
            5'h00, 5'h01, 5'h10, 5'h11: regimm_ok = 1'b1;
            default:                    regimm_ok = 1'b0;
        endcase
    endfunction

    // The register may only take a new descriptor if it is empty or being drained this edge.
    // A pending ORI blocks intake.
    assign req_ready = rst_b && ((state_q == StIdle) || ((state_q == StEmit) && ins_ready));
    assign accept    = req_valid && req_ready;
    assign ins_valid = (state_q != StIdle);
    assign handoff   = ins_valid && ins_ready;

    assign ins_word  = word_q;
    assign ins_last  = last_q;
    assign err_pulse = err_q;
    assign enc_count = count_q;

    // Decode the current descriptor into its first word, whether that word is the last one,
    // and an optional second word.
    always_comb begin
        dec_legal = 1'b0;
        dec_word0 = 32'h0000_0000;
        dec_last0 = 1'b1;
        dec_word1 = 32'h0000_0000;
        unique case (req_fmt)
            FmtR: begin
                dec_legal = funct_ok(req_funct);
                dec_word0 = {OpSpecial, req_rs, req_rt, req_rd, req_shamt, req_funct};
            end
            FmtI: begin
                dec_legal = iop_ok(req_op);
                dec_word0 = {req_op, req_rs, req_rt, req_imm[15:0]};
            end
            FmtRegimm: begin
                dec_legal = regimm_ok(req_rt);
                dec_word0 = {OpRegimm, req_rs, req_rt, req_imm[15:0]};
            end
            FmtJ: begin
                dec_legal = (req_op == 6'h02) || (req_op == 6'h03);
                dec_word0 = {req_op, req_target};
            end
            FmtLi: begin
                dec_legal = 1'b1;
                if (req_imm[31:16] == 16'h0000) begin
                    dec_word0 = {OpOri, 5'd0, req_rt, req_imm[15:0]};
                end else begin
                    dec_word0 = {OpLui, 5'd0, req_rt, req_imm[31:16]};
                    // The ORI is skipped when the low half is zero.
                    dec_last0 = (req_imm[15:0] == 16'h0000);
                    dec_word1 = {OpOri, req_rt, req_rt, req_imm[15:0]};
                end
            end
            FmtNop: begin
                dec_legal = 1'b1;
                dec_word0 = 32'h0000_0000;
            end
            FmtMove: begin
                dec_legal = 1'b1;
                dec_word0 = {OpSpecial, req_rs, 5'd0, req_rd, 5'd0, FnAddu};
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Next-state logic. A handoff drains the output register first.
    // A same-edge legal accept then overwrites it.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        pend_d  = pend_q;
        count_d = count_q;
        err_d   = accept && !dec_legal;

        if (handoff) begin
            count_d = count_q + 16'd1;
            if (state_q == StEmitHi) begin
                word_d  = pend_q;
                last_d  = 1'b1;
                state_d = StEmit;
            end else begin
                last_d  = 1'b0;
                state_d = StIdle;
            end
        end

        if (accept && dec_legal) begin
            word_d  = dec_word0;
            last_d  = dec_last0;
            pend_d  = dec_word1;
            state_d = dec_last0 ? StEmit : StEmitHi;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= StIdle;
            word_q  <= 32'h0000_0000;
            last_q  <= 1'b0;
            pend_q  <= 32'h0000_0000;
            err_q   <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

endmodule
